fetch_align_buffer: RTL and testbench
=====================================

# fetch_align_buffer

Fetch-side instruction aligner sitting directly downstream of the I-cache fetch-data extraction stage. It accepts 64-bit fetch blocks (fetch_data_t) tagged with their PC, holds them in an 8-parcel (16-bit parcel) buffer, and emits one aligned instruction per cycle to decode over a valid/ready handshake. Instructions may be 16-bit compressed or 32-bit, and a 32-bit instruction may straddle two fetch blocks.

## Interface
- No parameters; widths come from `FETCH_DATA_WIDTH` (64) and program_counter_t.
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_flush  in  1  empty buffer (redirect); highest priority
- i_fetch_valid  in  1  fetch block offered
- o_fetch_ready  out  1  buffer can take a block
- i_fetch_data  in  fetch_data_t  8 bytes, little-endian parcels 0..3
- i_fetch_pc  in  program_counter_t  PC of first useful byte; bits [2:1] select starting parcel
- o_instr_valid  out  1  instruction available
- i_instr_ready  in  1  decode accepts
- o_instr  out  32  instruction; upper 16 bits zero for compressed
- o_instr_pc  out  program_counter_t  PC of o_instr
- o_instr_compressed  out  1  o_instr is 16-bit

## Operation
- State: parcel array buf[0..7], count (0..8), head_pc, pc_valid.
- Accept: fetch handshake = i_fetch_valid & o_fetch_ready. Parcels from offset i_fetch_pc[2:1] through 3 append at buf[count] (after dequeue shift). If pc_valid==0, head_pc <= i_fetch_pc, pc_valid <= 1.
- Contiguity of successive blocks is upstream's obligation; buffer does not check PCs after the first.
- Length: buf[0][1:0] != 2'b11 → 16-bit (needs count>=1); == 2'b11 → 32-bit (needs count>=2).
- o_instr_valid = enough parcels & ~i_flush. Dequeue = o_instr_valid & i_instr_ready: shift buffer by 1 or 2 parcels, head_pc += 2 or 4, count decrements.
- Straddle: count==1 holding a 32-bit lower half → o_instr_valid=0 until next block arrives.
- o_fetch_ready = (count <= 4) & ~i_flush, computed from registered count only; no combinational path from i_instr_ready.
- Simultaneous accept and dequeue in one cycle: next count = count − consumed + appended (max 4+4=8, never overflows).
- Flush: count <= 0, pc_valid <= 0; any fetch or instr handshake that cycle is void (both outputs gated low).
- Reset: same as flush; buf contents don't-care. Outputs after reset: o_fetch_ready=1, o_instr_valid=0, o_instr_compressed=0; o_instr/o_instr_pc don't-care while invalid.

## Timing
- Block accepted in cycle N → first instruction valid in cycle N+1 (buffer registered; o_instr driven combinationally from registers).
- Sustained throughput: one instruction/cycle; one block/cycle while count<=4.
- Reset or flush asserted mid-straddle: partial instruction discarded, no output next cycle.

## Configuration
- FETCH_RVC_EN defined: 16-bit and 32-bit instructions as above; start offset uses i_fetch_pc[2:1].
- Undefined: every instruction is 32-bit, always consumes 2 parcels; start offset uses i_fetch_pc[2] only (i_fetch_pc[1] ignored); o_instr_compressed tied 0; head_pc steps by 4.

## Structure
- Shared package (include/instr.svh): parcel_t (16-bit), instr_t (32-bit), PARCELS_PER_FETCH = FETCH_DATA_WIDTH/16, FETCH_BUF_PARCELS = 8.
- One sub-module: fetch_parcel_shift, the combinational shift-by-consumed / insert-at-offset network producing the next buffer image.

## Test plan
- Reset, then block pc=0x1000 data=0x00000013_00000013 (two NOPs) → cycle+1 instr 0x00000013 pc 0x1000, next cycle pc 0x1004, compressed=0.
- RVC: block pc=0x2000 parcels {0x4501,0x4581,0x0013,0x0000} → 0x4501@0x2000 (c=1), 0x4581@0x2002 (c=1), 0x00000013@0x2004.
- Straddle: block pc=0x3004 parcels[2..3]={0x4501,0x0513}, next block parcels[0]=0x0000 → 0x4501@0x3004, stall, then 0x00000513@0x3006 after second block.
- Misaligned entry: pc=0x4006 → only parcel 3 used, first instr pc 0x4006.
- Backpressure: i_instr_ready=0, feed blocks → o_fetch_ready drops after count reaches 5; no data lost; resumes when count<=4.
- Flush mid-stream with count=3 and i_fetch_valid=1 → next cycle o_instr_valid=0, o_fetch_ready=1; new block pc=0x8000 yields instr pc 0x8000.

Source files
------------

// File: rtl/fetch_align_buffer_pkg.sv
// Shared types and sizing for the fetch aligner.
// Define FETCH_RVC_EN to enable 16-bit compressed instruction support.
package fetch_align_buffer_pkg;

  localparam int FETCH_DATA_WIDTH  = 64;
  localparam int PC_W              = 32;
  localparam int PARCELS_PER_FETCH = FETCH_DATA_WIDTH / 16;
  localparam int FETCH_BUF_PARCELS = 8;

`ifdef FETCH_RVC_EN
  localparam bit RVC_EN = 1'b1;
`else
  localparam bit RVC_EN = 1'b0;
`endif

  typedef logic [FETCH_DATA_WIDTH-1:0] fetch_data_t;
  typedef logic [PC_W-1:0]             program_counter_t;
  typedef logic [15:0]                 parcel_t;
  typedef logic [31:0]                 instr_t;

  // Without compressed support every instruction occupies two parcels.
  function automatic logic is_32bit(input logic [1:0] lo);
    return (lo == 2'b11) | ~RVC_EN;
  endfunction

endpackage

// File: rtl/fetch_align_buffer_shift.sv
// Next buffer image: drop consumed parcels from the front, then append the
// useful parcels of an accepted fetch block at the new tail.
module fetch_parcel_shift
  import fetch_align_buffer_pkg::*;
(
  input  parcel_t     buf_i [FETCH_BUF_PARCELS],
  input  logic [3:0]  count_i,
  input  logic [1:0]  consume_i,
  input  logic        append_i,
  input  logic [1:0]  offset_i,
  input  fetch_data_t data_i,
  output parcel_t     buf_o [FETCH_BUF_PARCELS],
  output logic [3:0]  count_o
);

  int base;
  int n_app;

  always_comb begin
    base  = int'(count_i) - int'(consume_i);
    n_app = append_i ? (PARCELS_PER_FETCH - int'(offset_i)) : 0;
    for (int j = 0; j < FETCH_BUF_PARCELS; j++) begin
      int src;
      int k;
      src = j + int'(consume_i);
      k   = int'(offset_i) + j - base;
      buf_o[j] = (src < FETCH_BUF_PARCELS) ? buf_i[src[2:0]] : '0;
      if (j >= base && j < base + n_app)
        buf_o[j] = data_i[16*k[1:0] +: 16];
    end
    count_o = 4'(base + n_app);
  end

endmodule

// File: rtl/fetch_align_buffer.sv
// Fetch-side aligner: buffers fetch blocks as parcels and emits one aligned
// instruction per cycle. FETCH_RVC_EN enables 16-bit compressed instructions.
module fetch_align_buffer
  import fetch_align_buffer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_fetch_valid,
  output logic             o_fetch_ready,
  input  fetch_data_t      i_fetch_data,
  input  program_counter_t i_fetch_pc,
  output logic             o_instr_valid,
  input  logic             i_instr_ready,
  output instr_t           o_instr,
  output program_counter_t o_instr_pc,
  output logic             o_instr_compressed
);

  parcel_t          pbuf_q [FETCH_BUF_PARCELS];
  parcel_t          pbuf_d [FETCH_BUF_PARCELS];
  logic [3:0]       count_q, count_d;
  program_counter_t head_pc_q;
  logic             pc_valid_q;

  logic       need32, enough, acc, deq;
  logic [1:0] consume, offset;

  assign need32 = is_32bit(pbuf_q[0][1:0]);
  assign enough = need32 ? (count_q >= 4'd2) : (count_q >= 4'd1);

  // Flush gates both handshakes so nothing moves in the redirect cycle.
  assign o_instr_valid = enough & ~i_flush;
  assign o_fetch_ready = (count_q <= 4'd4) & ~i_flush;

  assign deq     = o_instr_valid & i_instr_ready;
  assign acc     = i_fetch_valid & o_fetch_ready;
  assign consume = deq ? (need32 ? 2'd2 : 2'd1) : 2'd0;

`ifdef FETCH_RVC_EN
  assign offset = i_fetch_pc[2:1];
`else
  assign offset = {i_fetch_pc[2], 1'b0};
`endif

  assign o_instr            = need32 ? {pbuf_q[1], pbuf_q[0]} : {16'h0000, pbuf_q[0]};
  assign o_instr_pc         = head_pc_q;
  assign o_instr_compressed = o_instr_valid & ~need32;

  fetch_parcel_shift u_shift (
    .buf_i     (pbuf_q),
    .count_i   (count_q),
    .consume_i (consume),
    .append_i  (acc),
    .offset_i  (offset),
    .data_i    (i_fetch_data),
    .buf_o     (pbuf_d),
    .count_o   (count_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      count_q    <= '0;
      pc_valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (acc)
        pc_valid_q <= 1'b1;
    end
  end

  // Parcel storage and head PC carry no reset; count and pc_valid qualify them.
  always_ff @(posedge i_clk) begin
    pbuf_q <= pbuf_d;
    if (acc && !pc_valid_q)
      head_pc_q <= i_fetch_pc;
    else if (deq)
      head_pc_q <= head_pc_q + program_counter_t'({consume, 1'b0});
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Randomized and directed bench for fetch_align_buffer against a parcel-queue model.
module tb_fetch_align_buffer;
  import fetch_align_buffer_pkg::*;

`ifdef FETCH_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, flush, fetch_valid, fetch_ready;
  fetch_data_t      fetch_data;
  program_counter_t fetch_pc;
  logic             instr_valid, instr_ready, instr_comp;
  instr_t           instr;
  program_counter_t instr_pc;

  int n_cmp = 0;
  int n_bad = 0;

  parcel_t          mq [$];
  program_counter_t mpc = '0;
  bit               mpcv = 1'b0;

  localparam fetch_data_t NOP2 = 64'h00000013_00000013;

  always #5 clk = ~clk;

  fetch_align_buffer dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_flush            (flush),
    .i_fetch_valid      (fetch_valid),
    .o_fetch_ready      (fetch_ready),
    .i_fetch_data       (fetch_data),
    .i_fetch_pc         (fetch_pc),
    .o_instr_valid      (instr_valid),
    .i_instr_ready      (instr_ready),
    .o_instr            (instr),
    .o_instr_pc         (instr_pc),
    .o_instr_compressed (instr_comp)
  );

  function automatic bit m_len32(input logic [1:0] lo);
    return (lo == 2'b11) || !RVC;
  endfunction

  function automatic int m_offset(input logic [2:1] pcb);
    return RVC ? int'(pcb) : (pcb[2] ? 2 : 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare against the model at negedge, advance the model.
  task automatic step(input logic fv, input fetch_data_t d, input program_counter_t pc,
                      input logic ir, input logic fl, input logic rs);
    bit     len32, exp_vld, exp_rdy;
    instr_t exp_instr;
    @(posedge clk);
    #1;
    fetch_valid = fv; fetch_data = d; fetch_pc = pc;
    instr_ready = ir; flush = fl; rst = rs;
    @(negedge clk);
    len32     = (mq.size() > 0) ? m_len32(mq[0][1:0]) : 1'b1;
    exp_vld   = (mq.size() >= (len32 ? 2 : 1)) && !fl;
    exp_rdy   = (mq.size() <= 4) && !fl;
    exp_instr = 32'h0;
    if (exp_vld) exp_instr = len32 ? {mq[1], mq[0]} : {16'h0000, mq[0]};
    if (!rs) begin
      chk("fetch_ready", {31'h0, fetch_ready}, {31'h0, exp_rdy});
      chk("instr_valid", {31'h0, instr_valid}, {31'h0, exp_vld});
      if (exp_vld) begin
        chk("instr", instr, exp_instr);
        chk("instr_pc", instr_pc, mpc);
        chk("instr_compressed", {31'h0, instr_comp}, {31'h0, !len32});
      end
    end
    if (rs || fl) begin
      mq.delete();
      mpcv = 1'b0;
    end else begin
      if (exp_vld && ir) begin
        repeat (len32 ? 2 : 1) void'(mq.pop_front());
        mpc = mpc + (len32 ? 4 : 2);
      end
      if (fv && exp_rdy) begin
        for (int k = m_offset(pc[2:1]); k < 4; k++) mq.push_back(d[16*k +: 16]);
        if (!mpcv) begin
          mpc  = pc;
          mpcv = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input logic ir);
    step(1'b0, '0, '0, ir, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk_instr(input string name, input instr_t ei, input program_counter_t ep,
                           input logic ec);
    chk({name, "_valid"}, {31'h0, instr_valid}, 32'h1);
    chk({name, "_instr"}, instr, ei);
    chk({name, "_pc"}, instr_pc, ep);
    chk({name, "_comp"}, {31'h0, instr_comp}, {31'h0, ec});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_data = '0;
    fetch_pc = '0; instr_ready = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    idle(1'b0);
    chk("reset_fetch_ready", {31'h0, fetch_ready}, 32'h1);
    chk("reset_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("reset_compressed", {31'h0, instr_comp}, 32'h0);

    // Two NOPs
    step(1'b1, NOP2, 32'h1000, 1'b0, 1'b0, 1'b0);
    idle(1'b1); chk_instr("nop0", 32'h00000013, 32'h1000, 1'b0);
    idle(1'b1); chk_instr("nop1", 32'h00000013, 32'h1004, 1'b0);
    idle(1'b0); chk("nop_empty", {31'h0, instr_valid}, 32'h0);
    do_flush();

    // Mixed block
    step(1'b1, {16'h0000, 16'h0013, 16'h4581, 16'h4501}, 32'h2000, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_RVC_EN
    idle(1'b1); chk_instr("rvc0", 32'h00004501, 32'h2000, 1'b1);
    idle(1'b1); chk_instr("rvc1", 32'h00004581, 32'h2002, 1'b1);
    idle(1'b1); chk_instr("rvc2", 32'h00000013, 32'h2004, 1'b0);
`else
    idle(1'b1); chk_instr("w32_0", 32'h45814501, 32'h2000, 1'b0);
    idle(1'b1); chk_instr("w32_1", 32'h00000013, 32'h2004, 1'b0);
`endif
    do_flush();

    // Block entered at parcel 2
    step(1'b1, {16'h0513, 16'h4501, 32'h0}, 32'h3004, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_RVC_EN
    idle(1'b1); chk_instr("strad0", 32'h00004501, 32'h3004, 1'b1);
    idle(1'b1); chk("strad_stall", {31'h0, instr_valid}, 32'h0);
    step(1'b1, 64'h0, 32'h3008, 1'b1, 1'b0, 1'b0);
    chk("strad_stall2", {31'h0, instr_valid}, 32'h0);
    idle(1'b1); chk_instr("strad1", 32'h00000513, 32'h3006, 1'b0);
`else
    idle(1'b1); chk_instr("strad0", 32'h05134501, 32'h3004, 1'b0);
`endif
    do_flush();

`ifdef FETCH_RVC_EN
    step(1'b1, {16'h4501, 48'h1234_5678_9abc}, 32'h4006, 1'b0, 1'b0, 1'b0);
    idle(1'b1); chk_instr("misal", 32'h00004501, 32'h4006, 1'b1);
    idle(1'b1); chk("misal_empty", {31'h0, instr_valid}, 32'h0);
    do_flush();
`endif

    // Backpressure
    step(1'b1, NOP2, 32'h5000, 1'b0, 1'b0, 1'b0);
    step(1'b1, NOP2, 32'h5008, 1'b0, 1'b0, 1'b0);
    step(1'b1, NOP2, 32'h5010, 1'b0, 1'b0, 1'b0);
    chk("bp_full_ready", {31'h0, fetch_ready}, 32'h0);
    idle(1'b1); chk("bp8_ready", {31'h0, fetch_ready}, 32'h0);
    chk_instr("bp0", 32'h00000013, 32'h5000, 1'b0);
    idle(1'b1); chk("bp6_ready", {31'h0, fetch_ready}, 32'h0);
    chk_instr("bp1", 32'h00000013, 32'h5004, 1'b0);
    idle(1'b1); chk("bp4_ready", {31'h0, fetch_ready}, 32'h1);
    chk_instr("bp2", 32'h00000013, 32'h5008, 1'b0);
    idle(1'b1); chk_instr("bp3", 32'h00000013, 32'h500c, 1'b0);
    do_flush();

    // Flush mid-stream
    step(1'b1, NOP2, RVC ? 32'h6002 : 32'h6000, 1'b0, 1'b0, 1'b0);
    step(1'b1, NOP2, 32'h6008, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", {31'h0, instr_valid}, 32'h0);
    chk("flush_ready", {31'h0, fetch_ready}, 32'h0);
    idle(1'b0);
    chk("post_flush_valid", {31'h0, instr_valid}, 32'h0);
    chk("post_flush_ready", {31'h0, fetch_ready}, 32'h1);
    step(1'b1, NOP2, 32'h8000, 1'b0, 1'b0, 1'b0);
    idle(1'b1); chk_instr("redirect", 32'h00000013, 32'h8000, 1'b0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 4) != 0, {$urandom, $urandom}, $urandom, ($urandom % 3) != 0,
           ($urandom % 50) == 0, ($urandom % 300) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
